// File: rtl/ara_perf_cnt_bank.sv
// Bank of independent runtime counters: each channel counts from a start event until the
// monitored unit is idle, captures the runtime and exposes it through a muxed readout.
// Optional per-channel maximum tracking is enabled by defining ARA_PERF_CNT_MAX_EN.
module ara_perf_cnt_bank #(
  parameter  int unsigned NrCnt    = 4,
  parameter  int unsigned CntWidth = 64,
  parameter  int unsigned CapWidth = 16,
  localparam int unsigned SelWidth = (NrCnt > 1) ? $clog2(NrCnt) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NrCnt-1:0]    en_i,
  input  logic [NrCnt-1:0]    start_i,
  input  logic [NrCnt-1:0]    idle_i,
  input  logic [NrCnt-1:0]    clear_i,
  output logic [NrCnt-1:0]    cap_valid_o,
  output logic [NrCnt-1:0]    running_o,
  input  logic [SelWidth-1:0] rd_sel_i,
  output logic [CntWidth-1:0] rd_cnt_o,
  output logic [CntWidth-1:0] rd_buf_o,
  output logic [CapWidth-1:0] rd_ncap_o,
  output logic                rd_ovf_o,
  output logic [CntWidth-1:0] rd_max_o
);

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

  // Per-channel register views gathered for the readout mux.
  logic [NrCnt-1:0][CntWidth-1:0] cnt_all;
  logic [NrCnt-1:0][CntWidth-1:0] buf_all;
  logic [NrCnt-1:0][CapWidth-1:0] ncap_all;
  logic [NrCnt-1:0]               ovf_all;
`ifdef ARA_PERF_CNT_MAX_EN
  logic [NrCnt-1:0][CntWidth-1:0] max_all;
`endif

  for (genvar i = 0; i < NrCnt; i++) begin : g_ch
    state_e              state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [CntWidth-1:0] buf_q, buf_d;
    logic [CapWidth-1:0] ncap_q, ncap_d;
    logic                pend_q, pend_d;
    logic                ovf_q, ovf_d;
    logic                cap_valid_q;
    logic                capture;

    // NOTE: every signal gets a default before any branch, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      buf_d   = buf_q;
      ncap_d  = ncap_q;
      pend_d  = pend_q;
      ovf_d   = ovf_q;
      capture = 1'b0;

      if (clear_i[i]) begin
        state_d = StIdle;
        cnt_d   = '0;
        buf_d   = '0;
        ncap_d  = '0;
        pend_d  = 1'b0;
        ovf_d   = 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (en_i[i] && start_i[i]) begin
              state_d = StRun;
              pend_d  = 1'b1;
            end
          end
          StRun: begin
            // Saturate at all-ones; the exit edge still counts.
            if (cnt_q == '1) ovf_d = 1'b1;
            else             cnt_d = cnt_q + CntWidth'(1);

            // A start coinciding with idle keeps the measurement pending.
            capture = pend_q && idle_i[i] && !start_i[i];
            if (start_i[i])   pend_d = 1'b1;
            else if (capture) pend_d = 1'b0;

            if (capture) begin
              buf_d  = cnt_q;
              ncap_d = ncap_q + CapWidth'(1);
            end

            if (!en_i[i] && idle_i[i]) state_d = StIdle;
          end
          default: state_d = StIdle;
        endcase
      end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q     <= StIdle;
        cnt_q       <= '0;
        buf_q       <= '0;
        ncap_q      <= '0;
        pend_q      <= 1'b0;
        ovf_q       <= 1'b0;
        cap_valid_q <= 1'b0;
      end else begin
        state_q     <= state_d;
        cnt_q       <= cnt_d;
        buf_q       <= buf_d;
        ncap_q      <= ncap_d;
        pend_q      <= pend_d;
        ovf_q       <= ovf_d;
        cap_valid_q <= capture;
      end
    end

`ifdef ARA_PERF_CNT_MAX_EN
    logic [CntWidth-1:0] max_q, max_d;

    always_comb begin
      max_d = max_q;
      if (clear_i[i])                   max_d = '0;
      else if (capture && cnt_q > max_q) max_d = cnt_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) max_q <= '0;
      else         max_q <= max_d;
    end

    assign max_all[i] = max_q;
`endif

    assign cnt_all[i]     = cnt_q;
    assign buf_all[i]     = buf_q;
    assign ncap_all[i]    = ncap_q;
    assign ovf_all[i]     = ovf_q;
    assign running_o[i]   = (state_q == StRun);
    assign cap_valid_o[i] = cap_valid_q;
  end

  // Out-of-range selects match no channel and leave the outputs at zero.
  always_comb begin
    rd_cnt_o  = '0;
    rd_buf_o  = '0;
    rd_ncap_o = '0;
    rd_ovf_o  = 1'b0;
    for (int unsigned i = 0; i < NrCnt; i++) begin
      if (32'(rd_sel_i) == i) begin
        rd_cnt_o  = cnt_all[i];
        rd_buf_o  = buf_all[i];
        rd_ncap_o = ncap_all[i];
        rd_ovf_o  = ovf_all[i];
      end
    end
  end

`ifdef ARA_PERF_CNT_MAX_EN
  always_comb begin
    rd_max_o = '0;
    for (int unsigned i = 0; i < NrCnt; i++) begin
      if (32'(rd_sel_i) == i) rd_max_o = max_all[i];
    end
  end
`else
  assign rd_max_o = '0;
`endif

endmodule

// File: tb/tb_ara_perf_cnt_bank.sv
// Self-checking bench for ara_perf_cnt_bank: literal vector table, directed corner
// sequences and randomized traffic against a behavioural model.
module tb_ara_perf_cnt_bank;

  localparam int NrCnt    = 3;
  localparam int CntWidth = 8;
  localparam int CapWidth = 4;
  localparam int CntMax   = (1 << CntWidth) - 1;
  localparam int CapMod   = 1 << CapWidth;
`ifdef ARA_PERF_CNT_MAX_EN
  localparam bit MaxOn = 1'b1;
`else
  localparam bit MaxOn = 1'b0;
`endif

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic [NrCnt-1:0]    en_i, start_i, idle_i, clear_i;
  logic [NrCnt-1:0]    cap_valid_o, running_o;
  logic [1:0]          rd_sel_i;
  logic [CntWidth-1:0] rd_cnt_o, rd_buf_o, rd_max_o;
  logic [CapWidth-1:0] rd_ncap_o;
  logic                rd_ovf_o;

  ara_perf_cnt_bank #(
    .NrCnt   (NrCnt),
    .CntWidth(CntWidth),
    .CapWidth(CapWidth)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .en_i       (en_i),
    .start_i    (start_i),
    .idle_i     (idle_i),
    .clear_i    (clear_i),
    .cap_valid_o(cap_valid_o),
    .running_o  (running_o),
    .rd_sel_i   (rd_sel_i),
    .rd_cnt_o   (rd_cnt_o),
    .rd_buf_o   (rd_buf_o),
    .rd_ncap_o  (rd_ncap_o),
    .rd_ovf_o   (rd_ovf_o),
    .rd_max_o   (rd_max_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: one record per channel, advanced once per clock edge.
  bit m_run[NrCnt], m_pend[NrCnt], m_ovf[NrCnt], m_capv[NrCnt];
  int m_cnt[NrCnt], m_buf[NrCnt], m_ncap[NrCnt], m_max[NrCnt];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NrCnt; c++) begin
      m_run[c] = 0; m_pend[c] = 0; m_ovf[c] = 0; m_capv[c] = 0;
      m_cnt[c] = 0; m_buf[c] = 0; m_ncap[c] = 0; m_max[c] = 0;
    end
  endtask

  task automatic model_edge(input logic [NrCnt-1:0] en, st, idl, clr);
    for (int c = 0; c < NrCnt; c++) begin
      if (clr[c]) begin
        m_run[c] = 0; m_pend[c] = 0; m_ovf[c] = 0; m_capv[c] = 0;
        m_cnt[c] = 0; m_buf[c] = 0; m_ncap[c] = 0; m_max[c] = 0;
      end else if (m_run[c]) begin
        bit cap;
        cap = m_pend[c] && idl[c] && !st[c];
        if (cap) begin
          m_buf[c]  = m_cnt[c];
          m_ncap[c] = (m_ncap[c] + 1) % CapMod;
          if (m_cnt[c] > m_max[c]) m_max[c] = m_cnt[c];
          m_pend[c] = 0;
        end
        if (st[c]) m_pend[c] = 1;
        if (m_cnt[c] == CntMax) m_ovf[c] = 1;
        else                    m_cnt[c] = m_cnt[c] + 1;
        m_capv[c] = cap;
        m_run[c]  = !(!en[c] && idl[c]);
      end else begin
        m_capv[c] = 0;
        if (en[c] && st[c]) begin
          m_run[c]  = 1;
          m_pend[c] = 1;
        end
      end
    end
  endtask

  // Drive inputs, take one rising edge, advance the model, settle 1 time unit.
  task automatic step(input logic [NrCnt-1:0] en, st, idl, clr);
    en_i = en; start_i = st; idle_i = idl; clear_i = clr;
    @(posedge clk_i);
    model_edge(en, st, idl, clr);
    #1;
  endtask

  task automatic sel(input int ch);
    rd_sel_i = 2'(ch);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    en_i = '0; start_i = '0; idle_i = '0; clear_i = '0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    model_reset();
  endtask

  task automatic check_model(input string tag);
    check($sformatf("%s running", tag), 64'(running_o), 64'({m_run[2], m_run[1], m_run[0]}));
    check($sformatf("%s cap_valid", tag), 64'(cap_valid_o),
          64'({m_capv[2], m_capv[1], m_capv[0]}));
    for (int c = 0; c < NrCnt; c++) begin
      sel(c);
      check($sformatf("%s ch%0d cnt", tag, c), 64'(rd_cnt_o), 64'(m_cnt[c]));
      check($sformatf("%s ch%0d buf", tag, c), 64'(rd_buf_o), 64'(m_buf[c]));
      check($sformatf("%s ch%0d ncap", tag, c), 64'(rd_ncap_o), 64'(m_ncap[c]));
      check($sformatf("%s ch%0d ovf", tag, c), 64'(rd_ovf_o), 64'(m_ovf[c]));
      check($sformatf("%s ch%0d max", tag, c), 64'(rd_max_o), MaxOn ? 64'(m_max[c]) : 64'd0);
    end
  endtask

  typedef struct {
    logic en, st, idl, clr;
    logic run, capv;
    int   cnt, bufv, ncap, maxv;
  } vec_t;

  vec_t tbl[14];

  initial begin
    // Channel 0 basic capture, then clear with simultaneous start.
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,  0, 0, 0, 0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,  1, 0, 0, 0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,  2, 0, 0, 0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,  3, 0, 0, 0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,  4, 0, 0, 0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,  5, 0, 0, 0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,  6, 0, 0, 0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,  7, 0, 0, 0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,  8, 0, 0, 0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,  9, 0, 0, 0};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 10, 9, 1, 9};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 11, 9, 1, 9};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,  0, 0, 0, 0};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,  0, 0, 0, 0};

    rst_ni = 1'b0;
    en_i = '0; start_i = '0; idle_i = '0; clear_i = '0; rd_sel_i = '0;
    model_reset();
    #12;
    check_model("reset");
    do_reset();

    // Table sequence on channel 0.
    for (int k = 0; k < 14; k++) begin
      step({2'b00, tbl[k].en}, {2'b00, tbl[k].st}, {2'b00, tbl[k].idl}, {2'b00, tbl[k].clr});
      sel(0);
      check($sformatf("tbl%0d run", k), 64'(running_o[0]), 64'(tbl[k].run));
      check($sformatf("tbl%0d capv", k), 64'(cap_valid_o[0]), 64'(tbl[k].capv));
      check($sformatf("tbl%0d cnt", k), 64'(rd_cnt_o), 64'(tbl[k].cnt));
      check($sformatf("tbl%0d buf", k), 64'(rd_buf_o), 64'(tbl[k].bufv));
      check($sformatf("tbl%0d ncap", k), 64'(rd_ncap_o), 64'(tbl[k].ncap));
      check($sformatf("tbl%0d max", k), 64'(rd_max_o), MaxOn ? 64'(tbl[k].maxv) : 64'd0);
    end

    // Re-arm and stop: captures at E10 and E25, SW disable at E30, idle at E33.
    do_reset();
    step(3'b001, 3'b001, 3'b000, 3'b000);
    repeat (9) step(3'b001, 3'b000, 3'b000, 3'b000);
    step(3'b001, 3'b000, 3'b001, 3'b000);
    repeat (9) step(3'b001, 3'b000, 3'b000, 3'b000);
    step(3'b001, 3'b001, 3'b000, 3'b000);
    repeat (4) step(3'b001, 3'b000, 3'b000, 3'b000);
    step(3'b001, 3'b000, 3'b001, 3'b000);
    sel(0);
    check("rearm buf", 64'(rd_buf_o), 64'd24);
    check("rearm ncap", 64'(rd_ncap_o), 64'd2);
    check("rearm max", 64'(rd_max_o), MaxOn ? 64'd24 : 64'd0);
    repeat (4) step(3'b001, 3'b000, 3'b000, 3'b000);
    repeat (3) step(3'b000, 3'b000, 3'b000, 3'b000);
    check("stop run before idle", 64'(running_o[0]), 64'd1);
    step(3'b000, 3'b000, 3'b001, 3'b000);
    sel(0);
    check("stop run after idle", 64'(running_o[0]), 64'd0);
    check("stop cnt", 64'(rd_cnt_o), 64'd33);
    repeat (50) step(3'b000, 3'b000, 3'b000, 3'b000);
    sel(0);
    check("stop cnt frozen", 64'(rd_cnt_o), 64'd33);
    check_model("stop");

    // Saturation and capture of the saturated value.
    do_reset();
    step(3'b001, 3'b001, 3'b000, 3'b000);
    repeat (300) step(3'b001, 3'b000, 3'b000, 3'b000);
    sel(0);
    check("sat cnt", 64'(rd_cnt_o), 64'd255);
    check("sat ovf", 64'(rd_ovf_o), 64'd1);
    step(3'b001, 3'b000, 3'b001, 3'b000);
    sel(0);
    check("sat buf", 64'(rd_buf_o), 64'd255);
    check("sat capv", 64'(cap_valid_o[0]), 64'd1);
    check("sat ovf sticky", 64'(rd_ovf_o), 64'd1);

    // Clear priority on ch1 while ch0 keeps running.
    do_reset();
    step(3'b011, 3'b011, 3'b000, 3'b000);
    repeat (4) step(3'b011, 3'b000, 3'b000, 3'b000);
    step(3'b011, 3'b000, 3'b010, 3'b000);
    sel(1);
    check("clr pre buf1", 64'(rd_buf_o), 64'd4);
    step(3'b011, 3'b010, 3'b000, 3'b010);
    check("clr running", 64'(running_o), 64'b001);
    check("clr capv", 64'(cap_valid_o), 64'b000);
    sel(1);
    check("clr ch1 cnt", 64'(rd_cnt_o), 64'd0);
    check("clr ch1 buf", 64'(rd_buf_o), 64'd0);
    check("clr ch1 ncap", 64'(rd_ncap_o), 64'd0);
    check("clr ch1 max", 64'(rd_max_o), 64'd0);
    sel(0);
    check("clr ch0 cnt", 64'(rd_cnt_o), 64'd6);
    sel(3);
    check("sel oob cnt", 64'(rd_cnt_o), 64'd0);
    check("sel oob buf", 64'(rd_buf_o), 64'd0);
    check("sel oob ncap", 64'(rd_ncap_o), 64'd0);
    check("sel oob ovf", 64'(rd_ovf_o), 64'd0);
    check("sel oob max", 64'(rd_max_o), 64'd0);

    // Asynchronous reset while running, right after a capture.
    do_reset();
    step(3'b001, 3'b001, 3'b000, 3'b000);
    repeat (3) step(3'b001, 3'b000, 3'b000, 3'b000);
    step(3'b001, 3'b000, 3'b001, 3'b000);
    check("arst pre capv", 64'(cap_valid_o[0]), 64'd1);
    rst_ni = 1'b0;
    #1;
    check("arst running", 64'(running_o), 64'd0);
    check("arst capv", 64'(cap_valid_o), 64'd0);
    sel(0);
    check("arst cnt", 64'(rd_cnt_o), 64'd0);
    check("arst buf", 64'(rd_buf_o), 64'd0);
    check("arst ncap", 64'(rd_ncap_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    model_reset();

    // Randomized traffic on all channels against the model.
    for (int n = 0; n < 1500; n++) begin
      logic [NrCnt-1:0] en, st, idl, clr;
      for (int c = 0; c < NrCnt; c++) begin
        en[c]  = ($urandom_range(0, 7) != 0);
        st[c]  = ($urandom_range(0, 3) == 0);
        idl[c] = ($urandom_range(0, 1) == 0);
        clr[c] = ($urandom_range(0, 99) == 0);
      end
      step(en, st, idl, clr);
      check_model($sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
